// File: rtl/i2s_tx.sv
// Stereo I2S transmitter. It holds one left/right pair taken in over a
// valid/ready handshake and loads that pair into the output registers at each
// frame boundary. It generates BCLK/LRCLK from a free-running clk divider and
// serialises each sample MSB-first, one BCLK after every LRCLK edge.
module i2s_tx #(
    parameter int WD_IN    = 24,
    parameter int SLOT_WD  = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WD_IN-1:0] data_l,
    input  logic [WD_IN-1:0] data_r,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             i2s_bclk,
    output logic             i2s_lrclk,
    output logic             i2s_sdata,
    output logic             underrun
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(2 * SLOT_WD);

    localparam logic [DW-1:0] DIV_LAST   = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF   = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST   = BW'(2 * SLOT_WD - 1);
    localparam logic [BW-1:0] SLOT_LEN   = BW'(SLOT_WD);
    localparam logic [BW-1:0] FIRST_BIT  = BW'(1);
    localparam logic [BW-1:0] SAMPLE_TOP = BW'(WD_IN);

    // Channel index 0 is left, 1 is right, which matches the LRCLK level.
    logic [DW-1:0]            div_cnt;
    logic [BW-1:0]            bit_cnt;
    logic [1:0][WD_IN-1:0]    hold;
    logic [1:0][WD_IN-1:0]    sh;
    logic                     full;
    logic                     bclk_wrap;
    logic                     frame_load;
    logic                     accept;
    logic [BW-1:0]            slot_bit;
    logic [BW-1:0]            msb_ofs;
    logic [WD_IN-1:0]         chan_word;
    logic [WD_IN-1:0]         shifted;

    assign bclk_wrap    = (div_cnt == DIV_LAST);
    assign frame_load   = bclk_wrap && (bit_cnt == BIT_LAST);
    assign accept       = sample_valid && !full;
    assign sample_ready = !full;
    assign i2s_bclk     = (div_cnt >= DIV_HALF);
    assign i2s_lrclk    = (bit_cnt >= SLOT_LEN);

    // Free-running clk divider and bit position within the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            div_cnt <= bclk_wrap ? '0 : div_cnt + 1'b1;
            if (bclk_wrap)
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
    end

    // Holding register: an accept fills it, and a frame load drains it.
    // Accept has priority because it can only happen while empty, so a frame
    // load in that cycle has nothing to drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold <= '0;
            full <= 1'b0;
        end else if (accept) begin
            hold <= {data_r, data_l};
            full <= 1'b1;
        end else if (frame_load) begin
            full <= 1'b0;
        end
    end

    // Frame load: take the held pair, or send silence and flag the underrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh       <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= frame_load && !full;
            if (frame_load)
                sh <= full ? hold : '0;
        end
    end

    // Serial bit select: slot bit 1 carries the MSB, and bits past the sample are padding.
    always_comb begin
        slot_bit  = i2s_lrclk ? bit_cnt - SLOT_LEN : bit_cnt;
        chan_word = sh[i2s_lrclk];
        msb_ofs   = SAMPLE_TOP - slot_bit;
        shifted   = chan_word >> msb_ofs;
        i2s_sdata = 1'b0;
        if (slot_bit >= FIRST_BIT && slot_bit <= SAMPLE_TOP)
            i2s_sdata = shifted[0];
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at the default parameters. A monitor process
// decodes every frame into per-frame records. Those records are compared
// against a table of hand-computed frame contents for three scenarios.
module tb_i2s_tx;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] data_l = '0;
    logic [23:0] data_r = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, i2s_bclk, i2s_lrclk, i2s_sdata, underrun;

    i2s_tx #(.WD_IN(24), .SLOT_WD(32), .BCLK_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .data_l(data_l), .data_r(data_r),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state: n is the number of posedges since reset release.
    int          n = 0;
    logic        mon_en = 1'b0;
    logic        prev_sd = 1'b0;
    int          clk_err = 0;
    logic [23:0] fr_l [8];
    logic [23:0] fr_r [8];
    int          fr_pad [8];
    int          fr_ur [8];
    int          fr_urpos [8];
    logic        fr_rdy0 [8];
    logic        fr_rdy1 [8];

    typedef struct {
        int          phase;
        int          frame;
        logic [23:0] l;
        logic [23:0] r;
        int          ur;
    } frame_vec_t;

    frame_vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int t);
        int g;
        g = 0;
        while (n < t && g < 5000) begin
            step();
            g++;
        end
        if (n < t) begin
            errors++;
            $display("FAIL wait_until: reached cycle %0d, expected %0d", n, t);
        end
    endtask

    task automatic clear_mon();
        for (int k = 0; k < 8; k++) begin
            fr_l[k] = '0; fr_r[k] = '0; fr_pad[k] = 0; fr_ur[k] = 0;
            fr_urpos[k] = -1; fr_rdy0[k] = 1'b0; fr_rdy1[k] = 1'b0;
        end
        clk_err = 0;
        prev_sd = 1'b0;
    endtask

    // Hold reset, check the reset outputs, then release at a known point.
    task automatic do_reset();
        reset_n = 1'b0;
        mon_en = 1'b0;
        sample_valid = 1'b0;
        repeat (3) step();
        chk("rst_ready", 64'(sample_ready), 64'd1);
        chk("rst_bclk", 64'(i2s_bclk), 64'd0);
        chk("rst_lrclk", 64'(i2s_lrclk), 64'd0);
        chk("rst_sdata", 64'(i2s_sdata), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        clear_mon();
        n = 0;
        mon_en = 1'b1;
        reset_n = 1'b1;
    endtask

    task automatic check_frames(input int phase);
        chk($sformatf("p%0d_clk_pattern", phase), 64'(clk_err), 64'd0);
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].phase == phase) begin
                int f;
                f = vecs[i].frame;
                chk($sformatf("p%0d_f%0d_left", phase, f), 64'(fr_l[f]), 64'(vecs[i].l));
                chk($sformatf("p%0d_f%0d_right", phase, f), 64'(fr_r[f]), 64'(vecs[i].r));
                chk($sformatf("p%0d_f%0d_padding", phase, f), 64'(fr_pad[f]), 64'd0);
                chk($sformatf("p%0d_f%0d_underrun_cnt", phase, f), 64'(fr_ur[f]), 64'(vecs[i].ur));
                if (vecs[i].ur == 1)
                    chk($sformatf("p%0d_f%0d_underrun_pos", phase, f), 64'(fr_urpos[f]), 64'd0);
            end
        end
    endtask

    // Sample on the falling clk edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                int d, b, k, off, s;
                d = n % 4; b = (n / 4) % 64; k = n / 256; off = n % 256; s = b % 32;
                if (k < 8) begin
                    if (i2s_bclk !== 1'(d >= 2)) clk_err++;
                    if (i2s_lrclk !== 1'(b >= 32)) clk_err++;
                    if (d != 0 && i2s_sdata !== prev_sd) clk_err++;
                    prev_sd = i2s_sdata;
                    if (underrun === 1'b1) begin
                        fr_ur[k]++;
                        fr_urpos[k] = off;
                    end
                    if (off == 0) fr_rdy0[k] = sample_ready;
                    if (off == 1) fr_rdy1[k] = sample_ready;
                    if (d == 2) begin
                        if (s >= 1 && s <= 24) begin
                            if (b < 32) fr_l[k][24-s] = i2s_sdata;
                            else        fr_r[k][24-s] = i2s_sdata;
                        end else if (i2s_sdata !== 1'b0) begin
                            fr_pad[k]++;
                        end
                    end
                end
                n++;
            end
        end
    end

    initial begin
        int nacc, g;
        logic acc;

        // Phase 0: idle frame, single pair, underrun, then accept in the FL cycle.
        vecs[0]  = '{0, 0, 24'h000000, 24'h000000, 0};
        vecs[1]  = '{0, 1, 24'h800001, 24'h7FFFFE, 0};
        vecs[2]  = '{0, 2, 24'h000000, 24'h000000, 1};
        vecs[3]  = '{0, 3, 24'h000000, 24'h000000, 1};
        vecs[4]  = '{0, 4, 24'hABCDEF, 24'h13579B, 0};
        vecs[5]  = '{0, 5, 24'h000000, 24'h000000, 1};
        // Phase 1: continuous stream, one pair per frame.
        vecs[6]  = '{1, 0, 24'h000000, 24'h000000, 0};
        vecs[7]  = '{1, 1, 24'h123456, 24'hFEDCBA, 0};
        vecs[8]  = '{1, 2, 24'h234567, 24'hFDDBB9, 0};
        vecs[9]  = '{1, 3, 24'h345678, 24'hFCDAB8, 0};
        vecs[10] = '{1, 4, 24'h456789, 24'hFBD9B7, 0};
        // Phase 2: pair held when reset hits mid-frame, so it is never sent.
        vecs[11] = '{2, 0, 24'h000000, 24'h000000, 0};
        vecs[12] = '{2, 1, 24'h000000, 24'h000000, 1};

        // ---- Phase 0 ----
        do_reset();
        wait_until(10);
        data_l = 24'h800001; data_r = 24'h7FFFFE; sample_valid = 1'b1;
        chk("p0_ready_before", 64'(sample_ready), 64'd1);
        step();
        sample_valid = 1'b0;
        chk("p0_ready_dropped", 64'(sample_ready), 64'd0);
        // Present a pair exactly in the FL cycle that ends frame 2, with the holding register empty.
        wait_until(767);
        chk("p0_fl_ready", 64'(sample_ready), 64'd1);
        data_l = 24'hABCDEF; data_r = 24'h13579B; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("p0_fl_accepted", 64'(sample_ready), 64'd0);
        wait_until(1536);
        check_frames(0);

        // ---- Phase 1 ----
        do_reset();
        nacc = 0;
        data_l = 24'h123456; data_r = 24'hFEDCBA; sample_valid = 1'b1;
        g = 0;
        while (n < 1280 && g < 5000) begin
            acc = sample_valid && sample_ready;
            step();
            g++;
            if (acc) begin
                nacc++;
                data_l = 24'(24'h123456 + nacc * 24'h111111);
                data_r = 24'(24'hFEDCBA - nacc * 24'h010101);
            end
        end
        sample_valid = 1'b0;
        chk("p1_accept_count", 64'(nacc), 64'd5);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("p1_f%0d_ready_after_fl", k), 64'(fr_rdy0[k]), 64'd1);
            chk($sformatf("p1_f%0d_ready_after_accept", k), 64'(fr_rdy1[k]), 64'd0);
        end
        check_frames(1);

        // ---- Phase 2 ----
        do_reset();
        wait_until(5);
        data_l = 24'h55AA55; data_r = 24'h0F0F0F; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        wait_until(162);
        chk("p2_pre_bclk", 64'(i2s_bclk), 64'd1);
        chk("p2_pre_lrclk", 64'(i2s_lrclk), 64'd1);
        chk("p2_pre_ready", 64'(sample_ready), 64'd0);
        chk("p2_pre_clk_pattern", 64'(clk_err), 64'd0);
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("p2_async_ready", 64'(sample_ready), 64'd1);
        chk("p2_async_bclk", 64'(i2s_bclk), 64'd0);
        chk("p2_async_lrclk", 64'(i2s_lrclk), 64'd0);
        chk("p2_async_sdata", 64'(i2s_sdata), 64'd0);
        chk("p2_async_underrun", 64'(underrun), 64'd0);
        do_reset();
        wait_until(512);
        check_frames(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S transmitter on the output end of the audio equalizer. It accepts one 24-bit left/right sample pair per frame from the filter/mixer stage through a valid/ready handshake. It serialises the pair MSB-first onto the codec DAC's I2S lines and generates the BCLK and LRCLK that the codec slaves to. It also flags underruns when no sample pair is ready at a frame boundary.

## Interface
Parameters:
- WD_IN, 24: width of each signed sample; must satisfy WD_IN ≤ SLOT_WD-1.
- SLOT_WD, 32: BCLK periods per channel slot; a frame is 2*SLOT_WD BCLK periods.
- BCLK_DIV, 4: clk cycles per BCLK period; even, ≥ 2.

Ports:
- clk, in, 1: system clock; the only clock.
- reset_n, in, 1: asynchronous, active-low reset.
- data_l, in, WD_IN: signed left sample.
- data_r, in, WD_IN: signed right sample.
- sample_valid, in, 1: data_l and data_r are valid this cycle.
- sample_ready, out, 1: the holding register is empty; the pair is accepted when sample_valid && sample_ready.
- i2s_bclk, out, 1: bit clock.
- i2s_lrclk, out, 1: word select; 0 = left, 1 = right.
- i2s_sdata, out, 1: serial data.
- underrun, out, 1: one-clk pulse when a frame starts with no sample pair held.

## Operation
State:
- div_cnt: 0..BCLK_DIV-1, increments every clk and wraps.
- bit_cnt: 0..2*SLOT_WD-1, increments when div_cnt wraps to 0, and wraps itself.
- Holding register: data_l, data_r and a full flag.
- Shift registers: sh_l and sh_r.

Handshake:
- sample_ready = !full.
- On accept, capture data_l and data_r; set full.
- Inputs are ignored while sample_ready = 0.

Frame load event (FL) occurs in the cycle where div_cnt = BCLK_DIV-1 and bit_cnt = 2*SLOT_WD-1:
- If full: sh_l and sh_r take the holding contents; full clears.
- If !full: sh_l and sh_r load 0; underrun = 1 for the next clk cycle only.
- Simultaneous FL and accept cannot occur, because ready = 0 while full and FL only consumes when full. When FL runs with !full and valid is high, the accept wins: it sets full, the frame still loads zeros and flags underrun, and the new pair waits for the next FL.

Output decode, in the cycle with counters (d, b):
- i2s_bclk = (d ≥ BCLK_DIV/2).
- i2s_lrclk = (b ≥ SLOT_WD).
- s = b mod SLOT_WD; channel = left if b < SLOT_WD, otherwise right.
- i2s_sdata = bit [WD_IN-s] of the channel's shift register for 1 ≤ s ≤ WD_IN; otherwise 0.
- This gives the standard I2S one-BCLK MSB delay after each LRCLK edge.
- Data changes only at BCLK falling edges (d = 0) and is stable across the rising edge.
- Samples are sent as-is in two's complement; padding bits are 0.

## Timing
- Reset values: div_cnt = 0, bit_cnt = 0, full = 0, sh_l = sh_r = 0.
- Output values at reset: sample_ready = 1, i2s_bclk = 0, i2s_lrclk = 0, i2s_sdata = 0, underrun = 0.
- Outputs are registered or decoded purely from registers, so there is no combinational path from inputs to outputs.
- Reset asserted mid-frame returns all state to these values immediately; the pair in holding is discarded.
- The first frame after reset transmits zeros with no underrun pulse, because no FL has occurred yet.
- Frame length is 2*SLOT_WD*BCLK_DIV clk cycles (256 at the defaults).
- A pair accepted anywhere in frame k is transmitted in frame k+1. The left MSB appears BCLK_DIV clk cycles after the frame start (b = 1).
- sample_ready returns to 1 in the cycle after FL; at most one pair is accepted per frame.
- underrun goes high in the clk cycle after FL, which is the first cycle of the new frame, and stays high for one cycle only.

## Test plan
- **Reset:** hold reset_n = 0, release, and observe 256 clks with no input. Expect i2s_sdata = 0, a BCLK period of 4 clks, LRCLK high for clks 128..255, and no underrun.
- **Single pair:** offer data_l = 24'h800001 and data_r = 24'h7FFFFE during frame 0. Expect ready to drop the next cycle. In frame 1, left bits b = 1..24 read 1000…0001, right bits read 0111…1110, and all padding bits are 0.
- **Continuous stream:** valid held high with data incrementing per accept. Expect exactly one accept per frame, ready to rise one cycle after each FL, and samples to appear in order with no underrun.
- **Underrun:** stop valid after one pair. Expect the frame after that pair's frame to be all zeros, underrun pulsing for exactly 1 clk at its start, and BCLK/LRCLK continuing undisturbed.
- **Accept at FL with holding empty:** assert valid in the FL cycle. Expect that frame to be zeros with an underrun pulse, and the pair to be transmitted in the following frame.
- **Mid-frame reset:** assert reset_n = 0 at bit_cnt = 40 with a pair held. Expect all outputs to return to reset values asynchronously, sample_ready = 1, and the held pair never to be transmitted.
